sync_reg_pipe: RTL and testbench

Parametrised, DEPTH-stage, WIDTH-bit register pipeline with a synchronous active-high reset. It extends the single synchronous-reset D register to a chain of stages with a per-stage valid bit and valid/ready backpressure. Empty stages are collapsed so bubbles do not consume depth. A synchronous flush and an occupancy count are also provided. It sits between any producer and consumer that need a fixed retiming delay that can also absorb stalls.

---
 rtl/sync_reg_pipe.sv | 108 ++++++++++
 tb/tb_sync_reg_pipe.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sync_reg_pipe.sv
// sync_reg_pipe: DEPTH-stage, WIDTH-bit register pipeline with per-stage
// valid bits, valid/ready backpressure, bubble collapse, synchronous flush
// and a registered occupancy count.
// Build macro RESET_DATA_EN: when defined, rst and flush also load RST_VAL
// into every data register; otherwise only valid bits and count are reset.
module sync_reg_pipe #(
   parameter int unsigned      WIDTH   = 4,
   parameter int unsigned      DEPTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] r;
   logic [DEPTH-1:0] v_up;
   logic [WIDTH-1:0] d    [DEPTH];
   logic [WIDTH-1:0] d_up [DEPTH];
   logic             accept;
   logic             deliver;
   logic             run;

   // Ready chain from the output stage back to the input; a scalar carries
   // the running term so the vector never reads itself.
   always_comb begin
      r   = '0;
      run = ~v[DEPTH-1] | out_ready;
      r[DEPTH-1] = run;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         run = ~v[DEPTH-1-k] | run;
         r[DEPTH-1-k] = run;
      end
   end

   // Upstream source of each stage: producer for stage 0, previous stage otherwise.
   always_comb begin
      v_up    = '0;
      v_up[0] = in_valid;
      d_up[0] = in_data;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         v_up[k] = v[k-1];
         d_up[k] = d[k-1];
      end
   end

   assign in_ready  = r[0] & ~flush;
   assign out_valid = v[DEPTH-1] & ~flush;
   assign out_data  = d[DEPTH-1];
   assign accept    = in_valid & in_ready;
   assign deliver   = out_valid & out_ready;

   // Valid bits: cleared by rst/flush, otherwise each ready stage takes its upstream valid.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         v <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r[i]) v[i] <= v_up[i];
         end
      end
   end

   // Data registers move alongside the valid bits; reset only in the RESET_DATA_EN build.
   always_ff @(posedge clk) begin
`ifdef RESET_DATA_EN
      if (rst || flush) begin
         for (int unsigned i = 0; i < DEPTH; i++) d[i] <= RST_VAL;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r[i]) d[i] <= d_up[i];
         end
      end
`else
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (r[i]) d[i] <= d_up[i];
      end
`endif
   end

`ifndef RESET_DATA_EN
   // RST_VAL only drives hardware when data reset is enabled.
   logic [WIDTH-1:0] unused_rst_val;
   assign unused_rst_val = RST_VAL;
`endif

   // Occupancy: +1 on accept, -1 on deliver, cleared by rst/flush.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count <= '0;
      end else if (accept && !deliver) begin
         count <= count + CW'(1);
      end else if (deliver && !accept) begin
         count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_sync_reg_pipe.sv
// tb_sync_reg_pipe: table-driven vectors plus a scoreboard queue of accepted
// beats for sync_reg_pipe with WIDTH=4, DEPTH=3, RST_VAL=0.
module tb_sync_reg_pipe;

   localparam int DEPTH = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = 4'h0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic [1:0] count;

   int nvec = 0;
   int nerr = 0;
   bit mon_en = 1'b0;
   logic [3:0] exp_q[$];

   always #5 clk = ~clk;

   sync_reg_pipe #(.WIDTH(4), .DEPTH(3), .RST_VAL(4'h0)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count)
   );

   typedef struct {
      logic       rst, flush, iv;
      logic [3:0] din;
      logic       ordy;
      logic       e_ir, e_ov;
      logic [1:0] e_cnt;
      logic [3:0] e_dout;
   } vec_t;

   vec_t tbl[36];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard: push accepted beats, pop on delivery, track occupancy.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("sb count", 32'(count), 32'(exp_q.size()));
         chk("sb in_ready", 32'(in_ready),
             32'(!flush && (exp_q.size() < DEPTH || out_ready)));
         if (exp_q.size() == 0) chk("sb out_valid empty", 32'(out_valid), 32'd0);
         if (rst || flush) begin
            exp_q.delete();
         end else begin
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  nvec++; nerr++;
                  $display("FAIL sb unexpected beat: got %0h, expected none", out_data);
               end else begin
                  chk("sb out_data", 32'(out_data), 32'(exp_q.pop_front()));
               end
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //                rst flush iv din    ordy ir ov cnt   dout
      // streaming A,B,C
      tbl[0]  = '{1'b0,1'b0,1'b1,4'hA,1'b1,1'b1,1'b0,2'd0,4'h0};
      tbl[1]  = '{1'b0,1'b0,1'b1,4'hB,1'b1,1'b1,1'b0,2'd1,4'h0};
      tbl[2]  = '{1'b0,1'b0,1'b1,4'hC,1'b1,1'b1,1'b0,2'd2,4'h0};
      tbl[3]  = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,2'd3,4'hA};
      tbl[4]  = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,2'd2,4'hB};
      tbl[5]  = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,2'd1,4'hC};
      tbl[6]  = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b0,2'd0,4'h0};
      // backpressure 1..5
      tbl[7]  = '{1'b0,1'b0,1'b1,4'h1,1'b0,1'b1,1'b0,2'd0,4'h0};
      tbl[8]  = '{1'b0,1'b0,1'b1,4'h2,1'b0,1'b1,1'b0,2'd1,4'h0};
      tbl[9]  = '{1'b0,1'b0,1'b1,4'h3,1'b0,1'b1,1'b0,2'd2,4'h0};
      tbl[10] = '{1'b0,1'b0,1'b1,4'h4,1'b0,1'b0,1'b1,2'd3,4'h1};
      tbl[11] = '{1'b0,1'b0,1'b1,4'h4,1'b0,1'b0,1'b1,2'd3,4'h1};
      tbl[12] = '{1'b0,1'b0,1'b1,4'h4,1'b1,1'b1,1'b1,2'd3,4'h1};
      tbl[13] = '{1'b0,1'b0,1'b1,4'h5,1'b1,1'b1,1'b1,2'd3,4'h2};
      tbl[14] = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,2'd3,4'h3};
      tbl[15] = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,2'd2,4'h4};
      tbl[16] = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,2'd1,4'h5};
      tbl[17] = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b0,2'd0,4'h0};
      // bubble collapse
      tbl[18] = '{1'b0,1'b0,1'b1,4'h1,1'b0,1'b1,1'b0,2'd0,4'h0};
      tbl[19] = '{1'b0,1'b0,1'b0,4'h0,1'b0,1'b1,1'b0,2'd1,4'h0};
      tbl[20] = '{1'b0,1'b0,1'b1,4'h2,1'b0,1'b1,1'b0,2'd1,4'h0};
      tbl[21] = '{1'b0,1'b0,1'b0,4'h0,1'b0,1'b1,1'b1,2'd2,4'h1};
      tbl[22] = '{1'b0,1'b0,1'b0,4'h0,1'b0,1'b1,1'b1,2'd2,4'h1};
      tbl[23] = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,2'd2,4'h1};
      tbl[24] = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,2'd1,4'h2};
      tbl[25] = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b0,2'd0,4'h0};
      // flush of a full pipeline with a beat presented
      tbl[26] = '{1'b0,1'b0,1'b1,4'hA,1'b0,1'b1,1'b0,2'd0,4'h0};
      tbl[27] = '{1'b0,1'b0,1'b1,4'hB,1'b0,1'b1,1'b0,2'd1,4'h0};
      tbl[28] = '{1'b0,1'b0,1'b1,4'hC,1'b0,1'b1,1'b0,2'd2,4'h0};
      tbl[29] = '{1'b0,1'b1,1'b1,4'hD,1'b0,1'b0,1'b0,2'd3,4'h0};
      tbl[30] = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b0,2'd0,4'h0};
      // reset mid-stream
      tbl[31] = '{1'b0,1'b0,1'b1,4'h7,1'b1,1'b1,1'b0,2'd0,4'h0};
      tbl[32] = '{1'b0,1'b0,1'b1,4'h8,1'b1,1'b1,1'b0,2'd1,4'h0};
      tbl[33] = '{1'b1,1'b0,1'b1,4'h9,1'b1,1'b1,1'b0,2'd2,4'h0};
      tbl[34] = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b0,2'd0,4'h0};
      tbl[35] = '{1'b0,1'b0,1'b0,4'h0,1'b1,1'b1,1'b0,2'd0,4'h0};

      // Reset held for two edges.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset count", 32'(count), 32'd0);
      chk("reset in_ready", 32'(in_ready), 32'd1);
`ifdef RESET_DATA_EN
      chk("reset out_data", 32'(out_data), 32'h0);
`endif
      mon_en = 1'b1;

      for (int i = 0; i < 36; i++) begin
         @(posedge clk);
         #1;
         rst       = tbl[i].rst;
         flush     = tbl[i].flush;
         in_valid  = tbl[i].iv;
         in_data   = tbl[i].din;
         out_ready = tbl[i].ordy;
         @(negedge clk);
         chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
         chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
         if (tbl[i].e_ov) chk($sformatf("row%0d out_data", i), 32'(out_data), 32'(tbl[i].e_dout));
      end

      // Random traffic with occasional flush; scoreboard checks order and occupancy.
      for (int c = 0; c < 400; c++) begin
         @(posedge clk);
         #1;
         rst       = 1'b0;
         flush     = ($urandom_range(0, 31) == 0);
         in_valid  = $urandom_range(0, 1) != 0;
         in_data   = 4'($urandom_range(0, 15));
         out_ready = $urandom_range(0, 3) != 0;
      end

      // Bounded drain.
      @(posedge clk);
      #1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (!out_valid && count == 2'd0) break;
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("drain out_valid", 32'(out_valid), 32'd0);
      chk("drain count", 32'(count), 32'd0);
      chk("drain queue", 32'(exp_q.size()), 32'd0);
      mon_en = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
